// File: rtl/hazard_stall_ctrl.sv
// RV32I pipeline hazard/stall controller with dcache-miss stall FSM and watchdog.
// Optional perf counters are enabled with `define HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int MISS_TIMEOUT = 1024,
  parameter int TO_CNT_W     = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] reg1_srcD,
  input  logic [4:0] reg2_srcD,
  input  logic [4:0] reg1_srcE,
  input  logic [4:0] reg2_srcE,
  input  logic [4:0] reg_dstE,
  input  logic [4:0] reg_dstM,
  input  logic [4:0] reg_dstW,
  input  logic       reg_write_enM,
  input  logic       reg_write_enW,
  input  logic       load_E,
  input  logic       br,
  input  logic       jalr,
  input  logic       jal,
  input  logic       mem_req_M,
  input  logic       dcache_miss,
  output logic       flushF,
  output logic       flushD,
  output logic       flushE,
  output logic       flushM,
  output logic       flushW,
  output logic       bubbleF,
  output logic       bubbleD,
  output logic       bubbleE,
  output logic       bubbleM,
  output logic       bubbleW,
  output logic [1:0] op1_sel,
  output logic [1:0] op2_sel,
  output logic       err_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] loaduse_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic {RUN, MISS} state_e;

  state_e              state_q, state_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                miss_stall;
  logic                load_use;
  logic                br_flush;
  logic                jal_flush;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       wen_m,
    input logic [4:0] dst_m,
    input logic       wen_w,
    input logic [4:0] dst_w
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 5'd0) begin
      if (wen_m && dst_m == src)      sel = 2'b01;
      else if (wen_w && dst_w == src) sel = 2'b10;
    end
    return sel;
  endfunction

  always_comb begin
    miss_stall = dcache_miss &
                 ((state_q == RUN && mem_req_M) || state_q == MISS);
    load_use   = ~miss_stall & load_E & (reg_dstE != 5'd0) &
                 ((reg_dstE == reg1_srcD) | (reg_dstE == reg2_srcD));
    br_flush   = ~miss_stall & ~load_use & (br | jalr);
    jal_flush  = ~miss_stall & ~load_use & ~(br | jalr) & jal;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_req_M && dcache_miss) state_d = MISS;
      end
      MISS: begin
        if (dcache_miss)
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        else
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (cnt_d >= TO_CNT_W'(MISS_TIMEOUT)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset forces a full flush regardless of any pending hazard.
  always_comb begin
    flushF  = 1'b0;
    flushD  = br_flush | jal_flush;
    flushE  = load_use | br_flush;
    flushM  = 1'b0;
    flushW  = 1'b0;
    bubbleF = miss_stall | load_use;
    bubbleD = miss_stall | load_use;
    bubbleE = miss_stall;
    bubbleM = miss_stall;
    bubbleW = miss_stall;
    op1_sel = fwd_sel(reg1_srcE, reg_write_enM, reg_dstM,
                      reg_write_enW, reg_dstW);
    op2_sel = fwd_sel(reg2_srcE, reg_write_enM, reg_dstM,
                      reg_write_enW, reg_dstW);
    if (rst) begin
      flushF  = 1'b1;
      flushD  = 1'b1;
      flushE  = 1'b1;
      flushM  = 1'b1;
      flushW  = 1'b1;
      bubbleF = 1'b0;
      bubbleD = 1'b0;
      bubbleE = 1'b0;
      bubbleM = 1'b0;
      bubbleW = 1'b0;
      op1_sel = 2'b00;
      op2_sel = 2'b00;
    end
  end

  assign err_timeout = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_q, lu_q, fl_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      lu_q    <= '0;
      fl_q    <= '0;
    end else begin
      if (miss_stall) stall_q <= stall_q + 32'd1;
      if (load_use)   lu_q    <= lu_q + 32'd1;
      if (br_flush)   fl_q    <= fl_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign loaduse_cnt  = lu_q;
  assign flush_cnt    = fl_q;
`endif

endmodule
